// File: rtl/dct2d_sequencer.sv
// rtl/dct2d_sequencer.sv - 8x8 block sequencer driving a shared 1-D DCT engine (row pass, column pass, output).
module dct2d_sequencer #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_WIDTH-1:0] in_row,
    output logic                    dct_start,
    output logic [8*DATA_WIDTH-1:0] dct_x,
    input  logic [8*DATA_WIDTH-1:0] dct_y,
    input  logic                    dct_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*DATA_WIDTH-1:0] out_row,
    output logic                    out_last,
    output logic                    busy
);

    typedef enum logic [2:0] {
        LOAD,
        ROW_ISSUE,
        ROW_WAIT,
        COL_ISSUE,
        COL_WAIT,
        OUTPUT
    } state_t;

    state_t                state;
    logic [2:0]            idx;
    logic [DATA_WIDTH-1:0] buf_a [8][8];
    logic [DATA_WIDTH-1:0] buf_t [8][8];

    // Data buffers carry no reset; control state alone decides what is valid.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            for (int k = 0; k < 8; k++)
                buf_a[idx][k] <= in_row[k*DATA_WIDTH +: DATA_WIDTH];
        end else if (state == COL_WAIT && dct_valid) begin
            for (int u = 0; u < 8; u++)
                buf_a[u][idx] <= dct_y[u*DATA_WIDTH +: DATA_WIDTH];
        end
        if (state == ROW_WAIT && dct_valid) begin
            for (int k = 0; k < 8; k++)
                buf_t[idx][k] <= dct_y[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Column pass reads T transposed; everything else reads row idx of A.
    always_comb begin
        dct_x   = '0;
        out_row = '0;
        for (int k = 0; k < 8; k++) begin
            if (state == COL_ISSUE)
                dct_x[k*DATA_WIDTH +: DATA_WIDTH] = buf_t[k][idx];
            else
                dct_x[k*DATA_WIDTH +: DATA_WIDTH] = buf_a[idx][k];
            out_row[k*DATA_WIDTH +: DATA_WIDTH] = buf_a[idx][k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            idx       <= 3'd0;
            in_ready  <= 1'b1;
            dct_start <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state     <= ROW_ISSUE;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                            dct_start <= 1'b1;
                        end
                    end
                end
                ROW_ISSUE: begin
                    dct_start <= 1'b0;
                    state     <= ROW_WAIT;
                end
                ROW_WAIT: begin
                    if (dct_valid) begin
                        idx       <= idx + 3'd1;
                        dct_start <= 1'b1;
                        state     <= (idx == 3'd7) ? COL_ISSUE : ROW_ISSUE;
                    end
                end
                COL_ISSUE: begin
                    dct_start <= 1'b0;
                    state     <= COL_WAIT;
                end
                COL_WAIT: begin
                    if (dct_valid) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state     <= OUTPUT;
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                        end else begin
                            state     <= COL_ISSUE;
                            dct_start <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        idx      <= idx + 3'd1;
                        out_last <= (idx == 3'd6);
                        if (idx == 3'd7) begin
                            state     <= LOAD;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    idx       <= 3'd0;
                    in_ready  <= 1'b1;
                    dct_start <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dct2d_sequencer.sv
// tb/tb_dct2d_sequencer.sv - randomized bench for dct2d_sequencer with a 4-cycle behavioural engine.
module tb_dct2d_sequencer;
    localparam int DW = 24;
    localparam int VW = 8 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] in_row = '0;
    logic          dct_start;
    logic [VW-1:0] dct_x;
    logic [VW-1:0] dct_y;
    logic          dct_valid;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] out_row;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    dct2d_sequencer #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .dct_start(dct_start), .dct_x(dct_x), .dct_y(dct_y), .dct_valid(dct_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last), .busy(busy)
    );

    // Engine: identity or lane-sum; result valid 4 cycles after the start cycle.
    logic          eng_sum = 1'b0;
    logic          spur = 1'b0;
    int            eng_cnt;
    logic [VW-1:0] eng_x;
    logic          eng_valid;

    function automatic logic [VW-1:0] eng_fn(input logic [VW-1:0] x, input logic s);
        logic [DW-1:0] acc;
        logic [VW-1:0] r;
        if (!s) return x;
        acc = '0;
        for (int k = 0; k < 8; k++) acc = acc + x[k*DW +: DW];
        r = '0;
        r[DW-1:0] = acc;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_cnt   <= 0;
            eng_valid <= 1'b0;
        end else begin
            if (dct_start) begin
                eng_cnt <= 4;
                eng_x   <= dct_x;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
            end
            eng_valid <= (eng_cnt == 2);
        end
    end

    assign dct_valid = eng_valid | spur;
    assign dct_y     = eng_fn(eng_x, eng_sum);

    int cyc = 0;
    int n_start = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (dct_start === 1'b1) n_start <= n_start + 1;

    logic [DW-1:0] in_blk  [8][8];
    logic [DW-1:0] exp_blk [8][8];
    int n_pass = 0;
    int n_total = 0;
    int hs_cyc;
    int ov_cyc;

    function automatic logic [VW-1:0] pack_in(input int r);
        logic [VW-1:0] v;
        for (int c = 0; c < 8; c++) v[c*DW +: DW] = in_blk[r][c];
        return v;
    endfunction

    function automatic logic [VW-1:0] pack_exp(input int r);
        logic [VW-1:0] v;
        for (int c = 0; c < 8; c++) v[c*DW +: DW] = exp_blk[r][c];
        return v;
    endfunction

    // 2-D result of the chosen engine: identity leaves the block as-is,
    // lane-sum collapses the whole block into coefficient (0,0).
    task automatic build_expected();
        logic [DW-1:0] total;
        total = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                total = total + in_blk[r][c];
                exp_blk[r][c] = eng_sum ? '0 : in_blk[r][c];
            end
        if (eng_sum) exp_blk[0][0] = total;
    endtask

    task automatic fill_random();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) in_blk[r][c] = DW'($urandom());
    endtask

    task automatic load_block(input bit gaps);
        int n;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_row   = {6{$urandom()}};
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_row   = pack_in(r);
            n = 0;
            while (in_ready !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) begin
                n_total++;
                $display("FAIL load_timeout row=%0d in_ready=%b required 1", r, in_ready);
            end
            hs_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_row   = {6{$urandom()}};
    endtask

    task automatic collect_block(input int stall_row, input int stall_len, input int spur_row);
        int n;
        logic [VW-1:0] held;
        for (int u = 0; u < 8; u++) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 400) begin
                @(negedge clk);
                n++;
            end
            n_total++;
            if (n >= 400) begin
                $display("FAIL out_timeout row=%0d out_valid=%b required 1", u, out_valid);
                in_valid = 1'b0;
                return;
            end
            n_pass++;
            if (u == 0) begin
                ov_cyc   = cyc;
                in_valid = 1'b0;
            end
            n_total++;
            if (out_row !== pack_exp(u))
                $display("FAIL out_row u=%0d got=%h required=%h", u, out_row, pack_exp(u));
            else n_pass++;
            n_total++;
            if (out_last !== (u == 7))
                $display("FAIL out_last u=%0d got=%b required=%b", u, out_last, (u == 7));
            else n_pass++;
            if (u == stall_row) begin
                out_ready = 1'b0;
                held = out_row;
                repeat (stall_len) begin
                    @(negedge clk);
                    n_total++;
                    if (out_row !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || out_last !== (u == 7))
                        $display("FAIL stall_hold u=%0d row=%h valid=%b in_ready=%b required row=%h valid=1 in_ready=0",
                                 u, out_row, out_valid, in_ready, held);
                    else n_pass++;
                end
                out_ready = 1'b1;
            end
            if (u == spur_row) begin
                out_ready = 1'b0;
                spur = 1'b1;
                held = out_row;
                @(negedge clk);
                spur = 1'b0;
                n_total++;
                if (out_row !== held || out_valid !== 1'b1)
                    $display("FAIL spur_output u=%0d row=%h valid=%b required row=%h valid=1", u, out_row, out_valid, held);
                else n_pass++;
                out_ready = 1'b1;
            end
            @(negedge clk);
            n_total++;
            if (u < 7) begin
                if (in_ready !== 1'b0)
                    $display("FAIL in_ready_during_output u=%0d got=%b required 0", u, in_ready);
                else n_pass++;
            end else begin
                if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
                    $display("FAIL block_end in_ready=%b busy=%b out_valid=%b required 1/0/0", in_ready, busy, out_valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || dct_start !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0)
            $display("FAIL reset_outputs busy=%b start=%b out_valid=%b out_last=%b required 0", busy, dct_start, out_valid, out_last);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release in_ready=%b busy=%b required 1/0", in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_identity();
        eng_sum = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) in_blk[r][c] = DW'(8 * r + c);
        build_expected();
        load_block(1'b0);
        collect_block(-1, 0, -1);
    endtask

    task automatic test_sum();
        eng_sum = 1'b1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) in_blk[r][c] = DW'(10);
        build_expected();
        load_block(1'b1);
        collect_block(-1, 0, -1);
    endtask

    task automatic test_latency();
        int s0;
        eng_sum = 1'b0;
        fill_random();
        build_expected();
        s0 = n_start;
        load_block(1'b1);
        collect_block(-1, 0, -1);
        n_total++;
        if (ov_cyc - hs_cyc !== 81)
            $display("FAIL latency got=%0d required=81", ov_cyc - hs_cyc);
        else n_pass++;
        n_total++;
        if (n_start - s0 !== 16)
            $display("FAIL start_count got=%0d required=16", n_start - s0);
        else n_pass++;
    endtask

    task automatic test_stall();
        eng_sum = 1'b0;
        fill_random();
        build_expected();
        load_block(1'b0);
        collect_block(3, 5, -1);
    endtask

    task automatic test_spurious();
        eng_sum = 1'b1;
        fill_random();
        build_expected();
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        n_total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || dct_start !== 1'b0)
            $display("FAIL spur_load in_ready=%b busy=%b start=%b required 1/0/0", in_ready, busy, dct_start);
        else n_pass++;
        load_block(1'b1);
        collect_block(-1, 0, 5);
    endtask

    task automatic test_reset_mid();
        int s0;
        int n;
        eng_sum = 1'b0;
        fill_random();
        load_block(1'b0);
        s0 = n_start - 0;
        s0 = n_start;
        n = 0;
        while ((n_start - s0) < 11 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (n >= 500) $display("FAIL reset_mid_timeout starts=%0d required 11", n_start - s0);
        else n_pass++;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (dct_start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_mid_async start=%b out_valid=%b busy=%b required 0", dct_start, out_valid, busy);
        else n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_mid_release in_ready=%b busy=%b required 1/0", in_ready, busy);
        else n_pass++;
        fill_random();
        build_expected();
        load_block(1'b1);
        collect_block(-1, 0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            eng_sum = 1'($urandom_range(0, 1));
            fill_random();
            build_expected();
            load_block(1'b1);
            collect_block($urandom_range(0, 7), $urandom_range(1, 3), -1);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_sum();
        test_latency();
        test_stall();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1);
    end
endmodule
